// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of a combinational instruction ROM. Fetched words are
// buffered with their PC in a 2-entry queue; redirects flush it and refetch.
module instr_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_rdata,
  input  logic                  i_redirect,
  input  logic [PC_WIDTH-1:0]   i_redirect_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic                  o_fault
);

  typedef enum logic {MODE_RUN, MODE_HALT} mode_t;

  mode_t                 r_mode;
  logic [PC_WIDTH-1:0]   r_fetch_pc;
  logic                  r_fault_pend;
  logic [PC_WIDTH-1:0]   r_fault_pc;
  logic                  r_head;
  logic [1:0]            r_count;
  logic [PC_WIDTH-1:0]   r_ent_pc    [2];
  logic [DATA_WIDTH-1:0] r_ent_inst  [2];
  logic                  r_ent_fault [2];

  mode_t                 w_mode_next;
  logic [PC_WIDTH-1:0]   w_fetch_pc_next;
  logic                  w_fault_pend_next;
  logic [PC_WIDTH-1:0]   w_fault_pc_next;
  logic                  w_head_next;
  logic [1:0]            w_count_next;
  logic                  w_pop;
  logic                  w_push;
  logic [PC_WIDTH-1:0]   w_push_pc;
  logic [DATA_WIDTH-1:0] w_push_inst;
  logic                  w_push_fault;
  logic                  w_tail;

  assign o_rom_addr = r_fetch_pc[ADDR_WIDTH+1:2];
  assign o_valid    = (r_count != 2'd0);
  assign o_pc       = r_ent_pc[r_head];
  assign o_inst     = r_ent_inst[r_head];
  assign o_fault    = r_ent_fault[r_head];
  // With count = 2 the tail wraps onto the head slot, which is being popped.
  assign w_tail     = r_head ^ r_count[0];

  always_comb begin
    w_mode_next       = r_mode;
    w_fetch_pc_next   = r_fetch_pc;
    w_fault_pend_next = r_fault_pend;
    w_fault_pc_next   = r_fault_pc;
    w_head_next       = r_head;
    w_count_next      = r_count;
    w_pop             = 1'b0;
    w_push            = 1'b0;
    w_push_pc         = r_fetch_pc;
    w_push_inst       = i_rom_rdata;
    w_push_fault      = 1'b0;
    if (i_redirect) begin
      w_count_next = 2'd0;
      w_head_next  = 1'b0;
      if (i_redirect_pc[1:0] == 2'b00) begin
        w_fetch_pc_next   = i_redirect_pc;
        w_mode_next       = MODE_RUN;
        w_fault_pend_next = 1'b0;
      end else begin
        w_mode_next       = MODE_HALT;
        w_fault_pend_next = 1'b1;
        w_fault_pc_next   = i_redirect_pc;
      end
    end else begin
      w_pop = o_valid && i_ready;
      if (r_fault_pend) begin
        // Queue was flushed by the redirect, so the marker always has room.
        w_push            = 1'b1;
        w_push_pc         = r_fault_pc;
        w_push_inst       = '0;
        w_push_fault      = 1'b1;
        w_fault_pend_next = 1'b0;
      end else if (r_mode == MODE_RUN && (r_count != 2'd2 || w_pop)) begin
        w_push          = 1'b1;
        w_fetch_pc_next = r_fetch_pc + PC_WIDTH'(4);
      end
      if (w_pop) begin
        w_head_next = ~r_head;
      end
      w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_mode       <= MODE_RUN;
      r_fetch_pc   <= RESET_PC;
      r_fault_pend <= 1'b0;
      r_fault_pc   <= '0;
      r_head       <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_mode       <= w_mode_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_fault_pend <= w_fault_pend_next;
      r_fault_pc   <= w_fault_pc_next;
      r_head       <= w_head_next;
      r_count      <= w_count_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ent
    always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
        r_ent_pc[gi]    <= '0;
        r_ent_inst[gi]  <= '0;
        r_ent_fault[gi] <= 1'b0;
      end else if (w_push && (w_tail == 1'(gi))) begin
        r_ent_pc[gi]    <= w_push_pc;
        r_ent_inst[gi]  <= w_push_inst;
        r_ent_fault[gi] <= w_push_fault;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected heads, a
// negedge monitor compares every presented head and logs each handshake.
module tb_instr_fetch_unit;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] o_rom_addr;
  logic [DW-1:0] i_rom_rdata;
  logic          i_redirect;
  logic [PW-1:0] i_redirect_pc;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_inst;
  logic [PW-1:0] o_pc;
  logic          o_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PC_WIDTH(PW), .RESET_PC(32'h100)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .o_rom_addr(o_rom_addr),
    .i_rom_rdata(i_rom_rdata), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_inst(o_inst), .o_pc(o_pc), .o_fault(o_fault)
  );

  // ROM model: word i holds 0x1000 + i
  assign i_rom_rdata = 32'h1000 + 32'(o_rom_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic fault);
    exp_t e;
    e.pc    = pc;
    e.fault = fault;
    e.inst  = fault ? 32'h0 : 32'h1000 + {22'b0, pc[11:2]};
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid && !i_redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pc %h inst %h fault %b, expected no valid",
                 o_pc, o_inst, o_fault);
      end else begin
        mon_e = exp_q[0];
        check("head_pc", o_pc, mon_e.pc);
        check("head_inst", o_inst, mon_e.inst);
        check("head_fault", 32'(o_fault), 32'(mon_e.fault));
        if (i_ready) begin
          void'(exp_q.pop_front());
          $display("xfer pc=%h inst=%h fault=%b", o_pc, o_inst, o_fault);
        end
      end
    end
  end

  initial begin
    int n;
    int nvalid;
    rst_n = 1'b0; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rom_addr", 32'(o_rom_addr), 32'h40);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_inst", o_inst, 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_fault", 32'(o_fault), 32'h0);

    // Reset release, then a 5-cycle stall on the first valid head
    for (int i = 0; i < 20; i++) push_exp(32'h100 + 32'(4 * i), 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    n = 0;
    do begin tick; n++; end while (!o_valid && n < 10);
    check("first_valid_latency", 32'(n), 32'd1);
    repeat (5) tick;
    check("stall_rom_addr", 32'(o_rom_addr), 32'h42);
    check("stall_head_pc", o_pc, 32'h100);
    check("stall_head_inst", o_inst, 32'h1040);
    i_ready = 1'b1;
    repeat (6) tick;

    // Aligned redirect while a head is presented with ready high
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    exp_q.delete();
    for (int i = 0; i < 10; i++) push_exp(32'h200 + 32'(4 * i), 1'b0);
    tick;
    i_redirect = 1'b0;
    check("redir_bubble_valid", 32'(o_valid), 32'h0);
    tick;
    check("redir_target_valid", 32'(o_valid), 32'h1);
    check("redir_target_pc", o_pc, 32'h200);
    check("redir_target_inst", o_inst, 32'h1080);
    repeat (3) tick;

    // Misaligned redirect: one fault marker, then halted
    i_redirect = 1'b1; i_redirect_pc = 32'h202;
    exp_q.delete();
    push_exp(32'h202, 1'b1);
    tick;
    i_redirect = 1'b0;
    nvalid = 0;
    repeat (8) begin
      if (o_valid) nvalid++;
      tick;
    end
    check("halt_valid_cycles", 32'(nvalid), 32'd1);

    i_redirect = 1'b1; i_redirect_pc = 32'h300;
    for (int i = 0; i < 8; i++) push_exp(32'h300 + 32'(4 * i), 1'b0);
    tick;
    i_redirect = 1'b0;
    tick;
    check("resume_valid", 32'(o_valid), 32'h1);
    check("resume_pc", o_pc, 32'h300);
    repeat (3) tick;

    // PC wrap-around at the top of the address space
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    exp_q.delete();
    for (int i = 0; i < 8; i++) push_exp(32'hFFFF_FFFC + 32'(4 * i), 1'b0);
    tick;
    i_redirect = 1'b0;
    check("wrap_rom_addr_hi", 32'(o_rom_addr), 32'h3FF);
    tick;
    check("wrap_rom_addr_lo", 32'(o_rom_addr), 32'h000);
    check("wrap_pc_hi", o_pc, 32'hFFFF_FFFC);
    tick;
    check("wrap_pc_lo", o_pc, 32'h0);

    // Fill the queue, then assert reset between edges
    i_ready = 1'b0;
    repeat (3) tick;
    check("pre_reset_valid", 32'(o_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'h0);
    check("async_rst_inst", o_inst, 32'h0);
    check("async_rst_pc", o_pc, 32'h0);
    check("async_rst_fault", 32'(o_fault), 32'h0);
    check("async_rst_rom_addr", 32'(o_rom_addr), 32'h40);
    exp_q.delete();
    for (int i = 0; i < 10; i++) push_exp(32'h100 + 32'(4 * i), 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;
    i_ready = 1'b1;
    tick;
    check("restart_pc", o_pc, 32'h100);
    repeat (3) tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
